// File: rtl/inst_loader.sv
// rtl/inst_loader.sv - boot-time instruction memory loader fed by a framed byte stream
//
// Receives a program image frame {CNT_HI, CNT_LO, 4*N data bytes, CHK} and writes
// big-endian 32-bit words into instruction memory at BASE_ADDR + 4*index. The CPU is
// held in reset until the whole frame has been received and its XOR checksum matched.
//
// Ports:
//   clk, rst       clock; synchronous active-high reset
//   byte_valid     byte_data carries a stream byte
//   byte_data      stream byte
//   byte_ready     loader accepts a byte this cycle (combinational)
//   mem_we         instruction memory write strobe, one-cycle pulse
//   mem_addr       byte address of the write (holds when mem_we=0)
//   mem_wdata      write data (holds when mem_we=0)
//   cpu_rst        CPU reset, high until a successful load completes
//   done           sticky: load completed successfully
//   error          sticky: load failed (bad count, checksum or timeout)
//   words_loaded   number of words written so far

module inst_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int unsigned MAX_WORDS = 1024,
  parameter int unsigned TIMEOUT   = 1000,
  parameter int unsigned CNT_W     = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             cpu_rst,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] words_loaded
);

  typedef enum logic [2:0] {
    S_HDR_HI = 3'd0,
    S_HDR_LO = 3'd1,
    S_DATA   = 3'd2,
    S_CHK    = 3'd3,
    S_DONE   = 3'd4,
    S_ERROR  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;          // word count N from the header
  logic [7:0]       chk_q, chk_d;          // running XOR of accepted frame bytes
  logic [23:0]      shift_q, shift_d;      // first three bytes of the word in flight
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic [31:0]      idle_q, idle_d;
  logic             mem_we_q, mem_we_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic             cpu_rst_q, cpu_rst_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic [CNT_W-1:0] words_q, words_d;

  logic             xfer;
  logic [15:0]      n_hdr;
  logic             last_word;
  logic             in_frame;

  // Ready only in the receiving states; forced low during reset.
  always_comb begin
    byte_ready = 1'b0;
    if (!rst) begin
      byte_ready = (state_q == S_HDR_HI) || (state_q == S_HDR_LO) ||
                   (state_q == S_DATA)   || (state_q == S_CHK);
    end
  end

  assign xfer      = byte_valid && byte_ready;
  assign n_hdr     = {cnt_q[15:8], byte_data};
  // words_q counts completed writes, so it is also the index of the word being assembled.
  assign last_word = ((32'(words_q) + 32'd1) == 32'(cnt_q));
  assign in_frame  = (state_q == S_HDR_LO) || (state_q == S_DATA) || (state_q == S_CHK);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    chk_d       = chk_q;
    shift_d     = shift_q;
    byte_idx_d  = byte_idx_q;
    idle_d      = idle_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    words_d     = words_q;

    case (state_q)
      S_HDR_HI: begin
        if (xfer) begin
          cnt_d   = {byte_data, 8'h00};
          chk_d   = chk_q ^ byte_data;
          state_d = S_HDR_LO;
        end
      end
      S_HDR_LO: begin
        if (xfer) begin
          cnt_d = n_hdr;
          chk_d = chk_q ^ byte_data;
          if (n_hdr == 16'd0) begin
            state_d = S_CHK;
          end else if (32'(n_hdr) > MAX_WORDS) begin
            state_d = S_ERROR;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          chk_d      = chk_q ^ byte_data;
          shift_d    = {shift_q[15:0], byte_data};
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            // The write is registered, so the next word's first byte can be
            // accepted during the write cycle without disturbing it.
            mem_we_d    = 1'b1;
            mem_wdata_d = {shift_q, byte_data};
            mem_addr_d  = BASE_ADDR + (32'(words_q) << 2);
            words_d     = words_q + CNT_W'(1);
            if (last_word) begin
              state_d = S_CHK;
            end
          end
        end
      end
      S_CHK: begin
        if (xfer) begin
          state_d = (byte_data == chk_q) ? S_DONE : S_ERROR;
        end
      end
      default: begin
      end
    endcase

    // Inter-byte timeout once a frame has started; HDR_HI waits forever.
    if (in_frame) begin
      if (xfer) begin
        idle_d = 32'd0;
      end else if ((TIMEOUT != 0) && ((idle_q + 32'd1) >= TIMEOUT)) begin
        state_d = S_ERROR;
      end else begin
        idle_d = idle_q + 32'd1;
      end
    end

    // Terminal states are exclusive, so done and error can never both be set.
    done_d    = (state_d == S_DONE);
    error_d   = (state_d == S_ERROR);
    cpu_rst_d = (state_d != S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_HDR_HI;
      cnt_q       <= 16'd0;
      chk_q       <= 8'd0;
      shift_q     <= 24'd0;
      byte_idx_q  <= 2'd0;
      idle_q      <= 32'd0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= BASE_ADDR;
      mem_wdata_q <= 32'd0;
      cpu_rst_q   <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      words_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      chk_q       <= chk_d;
      shift_q     <= shift_d;
      byte_idx_q  <= byte_idx_d;
      idle_q      <= idle_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rst_q   <= cpu_rst_d;
      done_q      <= done_d;
      error_q     <= error_d;
      words_q     <= words_d;
    end
  end

  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign cpu_rst      = cpu_rst_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = words_q;

endmodule
